// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: round-robin arbiter for the register-file write port, with a pending-write scoreboard for decode hazards.
module reg_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int NREG = 32
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic [NREQ-1:0]      Req_Valid,
  input  logic [5*NREQ-1:0]    Req_Reg,
  input  logic [32*NREQ-1:0]   Req_Data,
  output logic [NREQ-1:0]      Req_Ready,
  input  logic                 Claim_Valid,
  input  logic [4:0]           Claim_Reg,
  input  logic [4:0]           Rs,
  input  logic [4:0]           Rt,
  output logic                 Rs_Busy,
  output logic                 Rt_Busy,
  output logic [NREG-1:0]      Busy_Mask,
  output logic                 Write,
  output logic [4:0]           Reg_Wb,
  output logic [31:0]          WriteData
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  logic [PW-1:0] ptr, g, idx;
  logic hs;
  logic [4:0] g_reg;
  logic [31:0] g_data;
  logic [NREG-1:0] busy, clr, set;
  // Scan from the farthest slot back to ptr so the closest valid requester wins.
  always_comb begin
    hs = 1'b0;
    g = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (Req_Valid[idx]) begin
        hs = 1'b1;
        g = idx;
      end
    end
  end
  assign Req_Ready = hs ? NREQ'(1) << g : '0;
  assign g_reg = Req_Reg[5*g +: 5];
  assign g_data = Req_Data[32*g +: 32];
  assign clr = (hs && g_reg != 5'd0) ? NREG'(1) << g_reg : '0;
  assign set = (Claim_Valid && Claim_Reg != 5'd0) ? NREG'(1) << Claim_Reg : '0;
  assign Busy_Mask = busy;
  // A write accepted this cycle is not yet in the register file, so it still counts as busy.
  assign Rs_Busy = (Rs != 5'd0) && (busy[Rs] || (hs && g_reg == Rs));
  assign Rt_Busy = (Rt != 5'd0) && (busy[Rt] || (hs && g_reg == Rt));
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ptr <= '0;
      busy <= '0;
      Write <= 1'b0;
      Reg_Wb <= '0;
      WriteData <= '0;
    end else begin
      busy <= (busy & ~clr) | set;
      Write <= hs && g_reg != 5'd0;
      if (hs) begin
        ptr <= (g == PW'(NREQ - 1)) ? '0 : g + PW'(1);
        Reg_Wb <= g_reg;
        WriteData <= g_data;
      end
    end
  end
endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Shares the register file's single write port (Write, Reg_Wb, WriteData) between NREQ writeback requesters, e.g. ALU result, load return and multi-cycle MUL/DIV.
- Uses round-robin arbitration with a valid/ready handshake.
- Keeps a pending-write scoreboard so decode can stall on Rs/Rt hazards.
- Sits between the execute/memory stages and the register file write port.

Parameters:
- NREQ, 3, number of writeback requesters (2..8).
- NREG, 32, number of architectural registers; register 0 is hardwired zero.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Rst_n  in  1  asynchronous active-low reset.
- Req_Valid  in  NREQ  per-requester writeback request.
- Req_Reg  in  5*NREQ  destination register id; requester i uses bits [5i+4:5i].
- Req_Data  in  32*NREQ  writeback data; requester i uses bits [32i+31:32i].
- Req_Ready  out  NREQ  one-hot grant, combinational; handshake = Valid & Ready.
- Claim_Valid  in  1  issue stage reserves a destination register.
- Claim_Reg  in  5  register being reserved.
- Rs  in  5  decode source register 1 query.
- Rt  in  5  decode source register 2 query.
- Rs_Busy  out  1  Rs has a pending write; combinational.
- Rt_Busy  out  1  Rt has a pending write; combinational.
- Busy_Mask  out  NREG  scoreboard contents; bit 0 is always 0.
- Write  out  1  register-file write enable; registered.
- Reg_Wb  out  5  register-file write address; registered.
- WriteData  out  32  register-file write data; registered.

Behaviour:
- Reset (async, Rst_n=0):
  - Write=0, Reg_Wb=0, WriteData=0.
  - Busy_Mask=0.
  - RR pointer = 0, so requester 0 has highest priority.
  - Req_Ready follows the reset pointer combinationally.
  - Reset mid-operation discards any in-flight grant; nothing is written.
- Arbitration (combinational, each cycle):
  - Search order is ptr, ptr+1, ..., ptr+NREQ-1, modulo NREQ.
  - First requester with Req_Valid=1 gets Req_Ready=1.
  - At most one Ready bit is set.
  - No valid requester: Req_Ready=0.
- Pointer update: on a handshake by requester g, ptr <= (g+1) mod NREQ at posedge. Otherwise ptr holds.
- Write port (1-cycle latency): on the posedge after a handshake by g:
  - Reg_Wb <= Req_Reg[g], WriteData <= Req_Data[g].
  - Write <= (Req_Reg[g] != 0).
- Write port with no handshake: Write <= 0; Reg_Wb and WriteData hold their last values.
- Register 0 as destination: the handshake still completes and consumes arbitration; Write stays 0.
- Requester behaviour is required, not checked: a requester keeps Valid and its Reg/Data stable until it gets Ready.
- Back-to-back: one write per cycle sustained. Multiple simultaneous requesters are served in RR order, one per cycle.
- Scoreboard set: Claim_Valid=1 and Claim_Reg != 0 sets Busy_Mask[Claim_Reg] at posedge. A claim of register 0 is ignored.
- Scoreboard clear: a handshake with Req_Reg[g] != 0 clears Busy_Mask[Req_Reg[g]] at the same posedge as the handshake. The clear does not wait for Write.
- Claim and clear of the same register in one cycle: set wins (new producer outstanding), bit stays 1.
- Claim of an already-busy register: bit stays 1. There is no count; the single-bit scoreboard means only one outstanding producer per register. The issue stage is required not to claim a register whose bit is already busy.
- Hazard query:
  - Rs_Busy = Busy_Mask[Rs] | (handshake pending this cycle to Rs, i.e. Write to Rs in flight).
  - Rt_Busy is defined the same way for Rt.
  - Rs=0 gives Rs_Busy=0; Rt=0 gives Rt_Busy=0.
  - Rationale: the register file updates at the posedge after the handshake, so a reader in the handshake cycle must still stall.
- The block has no data path into the register file other than through the write port.

Test Plan:
- Reset: assert Rst_n=0 mid-stream while Req_Valid=3'b111 → Write=0, Busy_Mask=0 immediately. After release with Req_Valid=3'b111, Req_Ready=3'b001.
- Round-robin: hold Req_Valid=3'b111 with Reg 5/6/7 and data 0xA/0xB/0xC for 4 cycles → grants 0,1,2,0. Write=1 for 4 cycles; Reg_Wb sequence 5,6,7,5 one cycle after each grant.
- Single requester: only req 2 valid, Reg=9, Data=0xDEADBEEF → Req_Ready=3'b100 in the same cycle. Next cycle Write=1, Reg_Wb=9, WriteData=0xDEADBEEF. Following cycle Write=0.
- Register zero: req 1 writes Reg=0 → Ready=1, Write stays 0, pointer advances to 2. Claim_Reg=0 leaves Busy_Mask=0.
- Scoreboard: claim r4 at cycle t → Busy_Mask[4]=1 at t+1, and Rs=4 gives Rs_Busy=1. Req 0 handshakes r4 at t+3 → Rs_Busy=1 during t+3, Busy_Mask[4]=0 and Rs_Busy=0 at t+4.
- Simultaneous claim/clear: claim r8 and handshake r8 in the same cycle → Busy_Mask[8]=1 next cycle. A later handshake to r8 clears it.
